// File: rtl/alu_operand_sequencer_if.sv
// rtl/alu_operand_sequencer_if.sv - request/ALU/response bundle; adds rsp_par when ALU_SEQ_PARITY_EN is defined
interface alu_operand_sequencer_if #(
  parameter int SEQ_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [9:0]       req_vec;
  logic [9:0]       alu_pi;
  logic [5:0]       alu_po;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [5:0]       rsp_data;
  logic [SEQ_W-1:0] rsp_seq;
  logic             busy;
`ifdef ALU_SEQ_PARITY_EN
  logic             rsp_par;

  modport slave (
    input  req_valid, req_vec, alu_po, rsp_ready,
    output req_ready, alu_pi, rsp_valid, rsp_data, rsp_seq, busy, rsp_par
  );

  modport master (
    output req_valid, req_vec, alu_po, rsp_ready,
    input  req_ready, alu_pi, rsp_valid, rsp_data, rsp_seq, busy, rsp_par
  );
`else
  modport slave (
    input  req_valid, req_vec, alu_po, rsp_ready,
    output req_ready, alu_pi, rsp_valid, rsp_data, rsp_seq, busy
  );

  modport master (
    output req_valid, req_vec, alu_po, rsp_ready,
    input  req_ready, alu_pi, rsp_valid, rsp_data, rsp_seq, busy
  );
`endif
endinterface

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - FIFO-fed issue stage holding ALU inputs for a multicycle settle, then capturing the result
// Optional ALU_SEQ_PARITY_EN adds a registered XOR-parity of the captured result.
module alu_operand_sequencer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int SEQ_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_operand_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  logic [9:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_req_ready;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [9:0]       r_alu_pi;
  logic [5:0]       r_rsp_data;
  logic             r_rsp_valid;
  logic [SEQ_W-1:0] r_rsp_seq;

  logic             w_empty;
  logic             w_push;
  logic             w_load;
  logic             w_capture;
  logic [PTR_W:0]   w_count_nxt;

  assign w_empty   = (r_count == '0);
  assign w_push    = bus.req_valid & r_req_ready;
  // A pop is exactly a load of alu_pi: from IDLE, or straight out of HOLD on the response handshake.
  assign w_load    = !w_empty &&
                     ((r_state == S_IDLE) || ((r_state == S_HOLD) && bus.rsp_ready));
  assign w_capture = (r_state == S_SETTLE) && (r_cnt == '0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_load})
      2'b10:   w_count_nxt = r_count + (PTR_W + 1)'(1);
      2'b01:   w_count_nxt = r_count - (PTR_W + 1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.req_vec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count     <= w_count_nxt;
      r_req_ready <= (w_count_nxt != CNT_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_alu_pi    <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_seq   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_alu_pi <= r_mem[r_rd_ptr];
            r_cnt    <= CNT_LOAD;
            r_state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (w_capture) begin
            r_rsp_data  <= bus.alu_po;
            r_rsp_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_seq   <= r_rsp_seq + SEQ_W'(1);
            if (w_load) begin
              r_alu_pi <= r_mem[r_rd_ptr];
              r_cnt    <= CNT_LOAD;
              r_state  <= S_SETTLE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_PARITY_EN
  logic r_rsp_par;
  logic w_po_par;

  assign w_po_par = ^bus.alu_po;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_par <= 1'b0;
    end else if (w_capture) begin
      r_rsp_par <= w_po_par;
    end
  end

  assign bus.rsp_par = r_rsp_par;
`endif

  assign bus.req_ready = r_req_ready;
  assign bus.alu_pi    = r_alu_pi;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_seq   = r_rsp_seq;
  assign bus.busy      = (r_state != S_IDLE) || !w_empty;

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Registered issue/capture stage that sits directly upstream of the 10-input, 6-output combinational ALU. It buffers incoming operand/opcode vectors in a small FIFO and drives one vector at a time onto the ALU inputs. It holds those inputs stable for a programmable number of settle cycles, which makes the ALU a multicycle path. It then captures the ALU result and presents it downstream with a valid/ready handshake.

## Interface
- FIFO_DEPTH, 4, request FIFO entries; power of two, ≥2
- SETTLE_CYCLES, 2, full cycles `alu_pi` is held before `alu_po` is sampled; ≥1
- SEQ_W, 8, width of response sequence counter

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request vector valid
- req_ready  out  1  FIFO can accept (registered, = FIFO not full)
- req_vec  in  10  operand/opcode vector; bit i maps to ALU input pi<i>
- alu_pi  out  10  drives ALU inputs pi0..pi9
- alu_po  in  6  ALU outputs po0..po5
- rsp_valid  out  1  captured result valid
- rsp_ready  in  1  downstream accepts result
- rsp_data  out  6  captured ALU result
- rsp_seq  out  SEQ_W  sequence number of the presented response
- busy  out  1  high when FSM ≠ IDLE or FIFO non-empty

## Operation
- FIFO push: `req_valid & req_ready`. Pop: the FSM loads `alu_pi`. Push and pop in the same cycle leave the count unchanged. No combinational bypass: a request always passes through the FIFO.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: if FIFO non-empty, at the edge load `alu_pi` ← head, pop, set cnt ← SETTLE_CYCLES−1, go to SETTLE.
  - SETTLE: if cnt==0, at the edge capture `rsp_data` ← `alu_po`, set `rsp_valid` ← 1, go to HOLD. Otherwise cnt−1.
  - HOLD: `rsp_valid`=1 and `rsp_data` stable. On `rsp_ready`:
    - `rsp_valid` ← 0 and `rsp_seq` ← `rsp_seq`+1 (wraps 2^SEQ_W−1→0).
    - If the FIFO is non-empty, load/pop the next head immediately and go to SETTLE. Otherwise go to IDLE.
- `alu_pi` changes only at a load edge and otherwise holds its last value, including in IDLE.
- `alu_po` is sampled only at the capture edge. Glitches at other times are ignored.
- `rsp_seq` of the k-th response after reset is k−1 (mod 2^SEQ_W).

## Timing
- Reset (asynchronous assert, synchronous release):
  - State IDLE, FIFO empty.
  - `alu_pi`=0, `rsp_data`=0, `rsp_valid`=0, `rsp_seq`=0, cnt=0.
  - `req_ready`=1, `busy`=0.
- Reset asserted mid-operation drops the in-flight result and all queued requests. Nothing is emitted after release.
- Latency with an empty pipe:
  - Request accepted at edge E.
  - Load at E+1.
  - Capture at E+1+SETTLE_CYCLES.
  - `rsp_valid` is high in the cycle after that edge (SETTLE_CYCLES=2: 3 edges).
- Back-to-back throughput with `rsp_ready` tied high: one result per SETTLE_CYCLES+1 cycles.
- Full: `req_ready`=0 when count==FIFO_DEPTH. It returns to 1 the cycle after a pop.
- `rsp_ready` asserted while `rsp_valid`=0 has no effect.
- `req_valid` while `req_ready`=0: the request is not accepted. The requester must hold the vector until it is accepted.

## Configuration
- `ALU_SEQ_PARITY_EN` defined:
  - Adds output `rsp_par` (1 bit) = XOR reduction of `alu_po`, captured on the same edge as `rsp_data`.
  - Reset value 0; held stable in HOLD.
- Not defined: the `rsp_par` port and its register are absent. All other behaviour is identical.

## Test plan
Bench models the ALU as `alu_po` = `alu_pi[5:0]` ^ `alu_pi[9:4]`. The model is deliberately glitched (random value) for the first cycle after every `alu_pi` change.
- Single request 10'h2A5, `rsp_ready`=1, SETTLE_CYCLES=2:
  - `alu_pi`=10'h2A5 from E+1.
  - `rsp_valid` high after edge E+3.
  - `rsp_data`=6'h25^6'h2A=6'h0F, `rsp_seq`=0.
  - `busy` low one cycle after the handshake.
- Burst of 5 requests with `rsp_ready`=0:
  - `req_ready` drops after the 5th accept (1 in HOLD + 4 queued).
  - Then release `rsp_ready`: 5 responses in push order, `rsp_seq` 0..4, one every 3 cycles.
- Backpressure: hold `rsp_ready`=0 for 10 cycles in HOLD.
  - `rsp_data` and `rsp_valid` stay constant.
  - `alu_pi` does not change.
- Async reset asserted during SETTLE with 2 entries queued:
  - All outputs return to reset values immediately.
  - No `rsp_valid` after release until a new request arrives.
- Run 257 transactions with SEQ_W=8: `rsp_seq` goes 255→0 on the 257th response.
- `ALU_SEQ_PARITY_EN` defined, request 10'h3FF: `rsp_data`=6'h3F^6'h3F=6'h00, `rsp_par`=0. Request 10'h001: `rsp_data`=6'h01, `rsp_par`=1.
